// File: rtl/lx_mem_interface_pkg.sv
// ---------------------------------------------------------------------------
// lx_mem_interface_pkg: cache/memory message encodings and helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lx_mem_interface_pkg;

  localparam int DEF_MSG_BITS = 4;

  localparam logic [DEF_MSG_BITS-1:0] NO_REQ   = 4'd0;
  localparam logic [DEF_MSG_BITS-1:0] R_REQ    = 4'd1;
  localparam logic [DEF_MSG_BITS-1:0] WB_REQ   = 4'd2;
  localparam logic [DEF_MSG_BITS-1:0] MEM_RESP = 4'd3;

  // Ceiling log2, with log2(1) = 0.
  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lx_mem_interface_if.sv
// ---------------------------------------------------------------------------
// lx_cache_mem_if / lx_mem_bus_if: cache-side and memory-side bundles. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lx_cache_mem_if
  import lx_mem_interface_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int CACHE_WIDTH  = 128,
  parameter int MSG_BITS     = DEF_MSG_BITS
);
  logic [MSG_BITS-1:0]     cache2mem_msg;
  logic [ADDRESS_BITS-1:0] cache2mem_address;
  logic [CACHE_WIDTH-1:0]  cache2mem_data;
  logic [MSG_BITS-1:0]     mem2cache_msg;
  logic [ADDRESS_BITS-1:0] mem2cache_address;
  logic [CACHE_WIDTH-1:0]  mem2cache_data;
  logic                    mem_intf_busy;
  logic [ADDRESS_BITS-1:0] mem_intf_address;
  logic                    mem_intf_address_valid;

  // master = the cache, slave = the memory interface block
  modport master (
    output cache2mem_msg, cache2mem_address, cache2mem_data,
    input  mem2cache_msg, mem2cache_address, mem2cache_data,
    input  mem_intf_busy, mem_intf_address, mem_intf_address_valid
  );
  modport slave (
    input  cache2mem_msg, cache2mem_address, cache2mem_data,
    output mem2cache_msg, mem2cache_address, mem2cache_data,
    output mem_intf_busy, mem_intf_address, mem_intf_address_valid
  );
endinterface

interface lx_mem_bus_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_we;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // master = the memory interface block, slave = main memory
  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lx_mem_interface.sv
// ---------------------------------------------------------------------------
// lx_mem_interface: serialises cache block fills/writebacks into word requests. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lx_mem_interface
  import lx_mem_interface_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int MSG_BITS          = DEF_MSG_BITS
) (
  input  logic           clock,
  input  logic           reset,
  lx_cache_mem_if.slave  cache,
  lx_mem_bus_if.master   mem
);

  localparam int CACHE_WORDS = 1 << CACHE_OFFSET_BITS;
  localparam int CNT_W       = CACHE_OFFSET_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CACHE_WORDS - 1);
  localparam logic [ADDRESS_BITS-1:0] OFFSET_MASK = ADDRESS_BITS'(CACHE_WORDS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_WAIT_CLR = 3'd4;

  logic [2:0]                             r_state;
  logic [2:0]                             w_next;
  logic [ADDRESS_BITS-1:0]                r_base;
  logic [CACHE_WORDS-1:0][DATA_WIDTH-1:0] r_block;
  logic [CNT_W-1:0]                       r_issue_cnt;
  logic [CNT_W-1:0]                       r_rcv_cnt;
  logic                                   r_is_read;
  logic                                   w_is_rd;
  logic                                   w_is_wb;
  logic                                   w_req_valid;
  logic                                   w_accept;
  logic                                   w_rcv;

  assign w_is_rd     = (cache.cache2mem_msg == MSG_BITS'(R_REQ));
  assign w_is_wb     = (cache.cache2mem_msg == MSG_BITS'(WB_REQ));
  assign w_req_valid = ((r_state == S_READ) || (r_state == S_WRITE)) && (r_issue_cnt <= LAST_WORD);
  assign w_accept    = w_req_valid && mem.mem_req_ready;
  assign w_rcv       = (r_state == S_READ) && mem.mem_rvalid && (r_rcv_cnt <= LAST_WORD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_is_rd)      w_next = S_READ;
        else if (w_is_wb) w_next = S_WRITE;
      end
      S_READ:     if (w_rcv && (r_rcv_cnt == LAST_WORD))      w_next = S_RESP;
      S_WRITE:    if (w_accept && (r_issue_cnt == LAST_WORD)) w_next = S_RESP;
      S_RESP:     w_next = S_WAIT_CLR;
      // Cache still holding the serviced request must not be re-accepted.
      S_WAIT_CLR: if (cache.cache2mem_msg == MSG_BITS'(NO_REQ)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_block     <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
      r_is_read   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_is_rd || w_is_wb)) begin
        r_base      <= cache.cache2mem_address & ~OFFSET_MASK;
        r_block     <= w_is_wb ? cache.cache2mem_data : '0;
        r_issue_cnt <= '0;
        r_rcv_cnt   <= '0;
        r_is_read   <= w_is_rd;
      end
      if (w_accept) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (w_rcv) begin
        r_block[r_rcv_cnt[CACHE_OFFSET_BITS-1:0]] <= mem.mem_rdata;
        r_rcv_cnt <= r_rcv_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mem.mem_req_valid            = w_req_valid;
    mem.mem_we                   = 1'b0;
    mem.mem_addr                 = '0;
    mem.mem_wdata                = '0;
    cache.mem2cache_msg          = MSG_BITS'(NO_REQ);
    cache.mem2cache_address      = '0;
    cache.mem2cache_data         = '0;
    cache.mem_intf_busy          = (r_state != S_IDLE);
    cache.mem_intf_address_valid = (r_state != S_IDLE);
    cache.mem_intf_address       = (r_state != S_IDLE) ? r_base : '0;
    if (w_req_valid)
      mem.mem_addr = r_base | ADDRESS_BITS'(r_issue_cnt[CACHE_OFFSET_BITS-1:0]);
    case (r_state)
      S_WRITE: begin
        mem.mem_we = 1'b1;
        if (w_req_valid) mem.mem_wdata = r_block[r_issue_cnt[CACHE_OFFSET_BITS-1:0]];
      end
      S_RESP: begin
        cache.mem2cache_msg     = MSG_BITS'(MEM_RESP);
        cache.mem2cache_address = r_base;
        if (r_is_read) cache.mem2cache_data = r_block;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lx_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_lx_mem_interface: randomized bench with memory model and golden block store. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lx_mem_interface;
  import lx_mem_interface_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int OB = 2;
  localparam int MB = 4;
  localparam int CW = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lx_cache_mem_if #(.ADDRESS_BITS(AW), .CACHE_WIDTH(CW), .MSG_BITS(MB)) cif ();
  lx_mem_bus_if   #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) mif ();

  lx_mem_interface #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .CACHE_OFFSET_BITS(OB), .MSG_BITS(MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cache(cif),
    .mem  (mif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main-memory storage (written by the DUT) and the bench's golden view (written per request)
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] golden    [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : dflt(a);
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : dflt(a);
  endfunction

  typedef struct {logic [31:0] a; int t;} pend_t;
  pend_t       pend[$];
  logic [63:0] wlog[$];
  int ready_period = 1;
  int ready_pct    = 100;
  int rv_gap       = 0;
  bit rv_gap_rand  = 1'b0;
  int cyc = 0, phase = 0, gap_left = 0;
  int rv_count = 0, resp_count = 0, stall_viol = 0;

  // Memory model: inputs change on the falling edge and are sampled on the next rising edge
  initial begin
    bit          prev_stall;
    logic [31:0] pa, pw;
    logic        pwe;
    prev_stall = 1'b0; pa = '0; pw = '0; pwe = 1'b0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rvalid    = 1'b0;
    mif.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pend.delete();
        gap_left = 0;
        prev_stall = 1'b0;
        mif.mem_req_ready = 1'b0;
        mif.mem_rvalid = 1'b0;
      end else begin
        if (prev_stall && !(mif.mem_req_valid && mif.mem_addr == pa && mif.mem_we == pwe &&
                            (!pwe || mif.mem_wdata == pw)))
          stall_viol++;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = $urandom;
        if (gap_left > 0) gap_left--;
        else if (pend.size() > 0 && pend[0].t <= cyc) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = mem_rd(pend[0].a);
          void'(pend.pop_front());
          rv_count++;
          gap_left = rv_gap_rand ? int'($urandom_range(rv_gap, 0)) : rv_gap;
        end
        phase++;
        if (ready_period == 0) mif.mem_req_ready = ($urandom_range(99, 0) < ready_pct);
        else                   mif.mem_req_ready = ((phase % ready_period) == 0);
        if (mif.mem_req_valid && mif.mem_req_ready) begin
          if (mif.mem_we) begin
            mem_store[mif.mem_addr] = mif.mem_wdata;
            wlog.push_back({mif.mem_addr, mif.mem_wdata});
          end else pend.push_back('{a: mif.mem_addr, t: cyc + 1});
        end
        prev_stall = mif.mem_req_valid && !mif.mem_req_ready;
        pa = mif.mem_addr; pw = mif.mem_wdata; pwe = mif.mem_we;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (cif.mem2cache_msg == MEM_RESP) resp_count++;
  end

  function automatic bit outs_nonzero();
    return |{cif.mem2cache_msg, cif.mem2cache_address, cif.mem2cache_data, cif.mem_intf_busy,
             cif.mem_intf_address, cif.mem_intf_address_valid, mif.mem_req_valid, mif.mem_we,
             mif.mem_addr, mif.mem_wdata};
  endfunction

  // One complete cache request: issue, wait for MEM_RESP, hold, release, return to idle
  task automatic do_req(input string tag, input logic [3:0] msg, input logic [31:0] addr,
                        input logic [127:0] data, input int hold_after,
                        output int lat, output logic [127:0] rdata_o);
    logic [31:0]  base, r_addr;
    logic [127:0] exp_blk, r_data;
    logic [63:0]  wgot;
    bit           got;
    int           viol, n, sv;
    base = addr & ~32'h3;
    n = 0;
    while (cif.mem_intf_busy && n < 100) begin @(negedge clock); n++; end
    chk({tag, " idle"}, cif.mem_intf_busy, 0);
    wlog.delete();
    sv = stall_viol;
    for (int i = 0; i < 4; i++)
      exp_blk[i*32 +: 32] = (msg == R_REQ) ? gold_rd(base + i) : 32'h0;
    cif.cache2mem_msg = msg; cif.cache2mem_address = addr; cif.cache2mem_data = data;
    got = 1'b0; lat = 0; viol = 0; r_addr = '1; r_data = '1;
    for (int i = 1; i <= 400 && !got; i++) begin
      @(negedge clock);
      if (cif.mem2cache_msg == MEM_RESP) begin
        got = 1'b1; lat = i;
        r_addr = cif.mem2cache_address; r_data = cif.mem2cache_data;
      end else if (!(cif.mem_intf_busy && cif.mem_intf_address_valid &&
                     cif.mem_intf_address == base)) viol++;
    end
    rdata_o = r_data;
    chk({tag, " resp seen"}, got, 1);
    chk({tag, " resp addr"}, r_addr, base);
    chk({tag, " resp data"}, r_data, exp_blk);
    chk({tag, " busy status"}, viol, 0);
    if (msg == WB_REQ) begin
      chk({tag, " write count"}, wlog.size(), 4);
      for (int i = 0; i < 4; i++) begin
        wgot = (i < wlog.size()) ? wlog[i] : '1;
        chk($sformatf("%s write%0d", tag, i), wgot, {base + i, data[i*32 +: 32]});
        golden[base + i] = data[i*32 +: 32];
      end
    end
    chk({tag, " stall stable"}, stall_viol - sv, 0);
    viol = 0;
    for (int i = 0; i < hold_after; i++) begin
      @(negedge clock);
      if (mif.mem_req_valid || cif.mem2cache_msg != NO_REQ || !cif.mem_intf_busy) viol++;
    end
    cif.cache2mem_msg = NO_REQ;
    @(negedge clock);
    if (cif.mem2cache_msg != NO_REQ) viol++;
    chk({tag, " post resp"}, viol, 0);
    n = 0;
    while (cif.mem_intf_busy && n < 10) begin @(negedge clock); n++; end
    chk({tag, " back idle"}, cif.mem_intf_busy, 0);
  endtask

  initial begin
    int           lat, n, rc0, resp0, viol;
    logic [127:0] blk;
    logic [3:0]   msg;
    cif.cache2mem_msg = NO_REQ; cif.cache2mem_address = '0; cif.cache2mem_data = '0;
    repeat (3) @(negedge clock);
    chk("reset outputs", outs_nonzero(), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle after reset", cif.mem_intf_busy, 0);

    // Directed read with fixed memory contents and minimum latency
    mem_store[32'h11110004] = 32'h11111111; golden[32'h11110004] = 32'h11111111;
    mem_store[32'h11110005] = 32'h22222222; golden[32'h11110005] = 32'h22222222;
    mem_store[32'h11110006] = 32'h33333333; golden[32'h11110006] = 32'h33333333;
    mem_store[32'h11110007] = 32'h44444444; golden[32'h11110007] = 32'h44444444;
    ready_period = 1; rv_gap = 0; rv_gap_rand = 1'b0;
    do_req("t1", R_REQ, 32'h11110004, '0, 0, lat, blk);
    chk("t1 latency", lat, 6);
    chk("t1 block", blk, 128'h44444444_33333333_22222222_11111111);

    // Writeback with ready toggling
    ready_period = 2;
    do_req("t2", WB_REQ, 32'h00AB0012, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, lat, blk);
    do_req("t2 readback", R_REQ, 32'h00AB0010, '0, 0, lat, blk);

    // Read with rvalid gaps and ready low two of every three cycles
    ready_period = 3; rv_gap = 3;
    do_req("t3", R_REQ, 32'h00AB0011, '0, 0, lat, blk);

    // Request held after MEM_RESP must not be re-accepted
    ready_period = 1; rv_gap = 0;
    do_req("t4", R_REQ, 32'h2222_0040, '0, 5, lat, blk);
    do_req("t4 next", WB_REQ, 32'h2222_0044, {4{32'hCAFE0001}}, 0, lat, blk);

    // Reset in the middle of a read
    rv_gap = 5; rc0 = rv_count; resp0 = resp_count;
    cif.cache2mem_msg = R_REQ; cif.cache2mem_address = 32'h0BAD0008;
    n = 0;
    while ((rv_count - rc0) < 2 && n < 100) begin @(negedge clock); n++; end
    chk("t5 two words", (rv_count - rc0) >= 2, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("t5 async clear", outs_nonzero(), 0);
    cif.cache2mem_msg = NO_REQ;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("t5 no resp", resp_count - resp0, 0);
    chk("t5 idle", cif.mem_intf_busy, 0);
    rv_gap = 0;
    do_req("t5 reread", R_REQ, 32'h0BAD0008, '0, 0, lat, blk);

    // Unknown message in IDLE
    viol = 0;
    cif.cache2mem_msg = MEM_RESP; cif.cache2mem_address = 32'h3333_0000;
    repeat (6) begin
      @(negedge clock);
      if (cif.mem_intf_busy || mif.mem_req_valid) viol++;
    end
    cif.cache2mem_msg = NO_REQ;
    chk("t6 ignored", viol, 0);

    // Random traffic over a small set of blocks so reads observe earlier writebacks
    for (int k = 0; k < 30; k++) begin
      msg = ($urandom_range(1, 0) == 1) ? WB_REQ : R_REQ;
      ready_period = $urandom_range(3, 0);
      ready_pct    = $urandom_range(100, 30);
      rv_gap_rand  = 1'b1;
      rv_gap       = $urandom_range(3, 0);
      do_req($sformatf("rnd%0d", k), msg, 32'h00C00000 | ($urandom & 32'h3F),
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(2, 0), lat, blk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
